// File: rtl/ro_pair_scheduler.sv
// RO-PUF pair scheduler: picks two distinct ring oscillators (LFSR or sequential),
// then sequences a settle phase and a gated measurement window.
module ro_pair_scheduler #(
    parameter int NUM_RO = 16,
    parameter int SEL_W  = $clog2(NUM_RO),
    parameter int LFSR_W = 8,
    parameter int SETTLE = 16,
    parameter int WINDOW = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              pair_valid,
    output logic [SEL_W-1:0]  ro1_sel,
    output logic [SEL_W-1:0]  ro2_sel,
    output logic [NUM_RO-1:0] ro_enable,
    output logic              meas_en,
    output logic              done
);

    localparam int MAX_CNT = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [LFSR_W-1:0] lfsr, lfsr_n;
    logic [SEL_W-1:0]  k, k_n;
    logic              mode_q, mode_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [SEL_W-1:0]  ro1_n, ro2_n;
    logic [NUM_RO-1:0] en_n;
    logic              pv_n, meas_n, done_n, busy_n;

    logic [LFSR_W-1:0] seed_fix, step_src, step_val;
    logic              fb;
    logic [SEL_W-1:0]  a_rand, b_raw, b_rand, pick_a, pick_b;

    // A zero seed would lock the LFSR; coincident load+start steps the new seed.
    assign seed_fix = (seed == '0) ? LFSR_W'(1) : seed;
    assign step_src = seed_load ? seed_fix : lfsr;

    generate
        if (LFSR_W == 16) begin : g_fb16
            assign fb = step_src[15] ^ step_src[14] ^ step_src[12] ^ step_src[3];
        end else if (LFSR_W == 12) begin : g_fb12
            assign fb = step_src[11] ^ step_src[5] ^ step_src[3] ^ step_src[0];
        end else begin : g_fb8
            assign fb = step_src[7] ^ step_src[5] ^ step_src[4] ^ step_src[3];
        end
    endgenerate

    assign step_val = {step_src[LFSR_W-2:0], fb};

    assign a_rand = lfsr[SEL_W-1:0];
    assign b_raw  = lfsr[2*SEL_W-1:SEL_W];
    assign b_rand = (a_rand == b_raw) ? (a_rand ^ SEL_W'(1)) : b_raw;
    assign pick_a = mode_q ? k : a_rand;
    assign pick_b = mode_q ? (k + SEL_W'(1)) : b_rand;

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        k_n     = k;
        mode_n  = mode_q;
        cnt_n   = cnt;
        ro1_n   = ro1_sel;
        ro2_n   = ro2_sel;
        en_n    = ro_enable;
        pv_n    = pair_valid;
        meas_n  = meas_en;
        done_n  = 1'b0;
        busy_n  = busy;
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            en_n    = '0;
            meas_n  = 1'b0;
            pv_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seed_load) lfsr_n = seed_fix;
                    if (start) begin
                        state_n = S_PICK;
                        mode_n  = mode;
                        busy_n  = 1'b1;
                        pv_n    = 1'b0;
                        if (!mode) lfsr_n = step_val;
                    end
                end
                S_PICK: begin
                    ro1_n   = pick_a;
                    ro2_n   = pick_b;
                    en_n    = (NUM_RO'(1) << pick_a) | (NUM_RO'(1) << pick_b);
                    pv_n    = 1'b1;
                    cnt_n   = CNT_W'(SETTLE - 1);
                    state_n = S_SETTLE;
                    if (mode_q) k_n = k + SEL_W'(1);
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state_n = S_MEASURE;
                        meas_n  = 1'b1;
                        cnt_n   = CNT_W'(WINDOW - 1);
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (cnt == '0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        en_n    = '0;
                        meas_n  = 1'b0;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_W'(1);
            k          <= '0;
            mode_q     <= 1'b0;
            cnt        <= '0;
            ro1_sel    <= '0;
            ro2_sel    <= SEL_W'(1);
            ro_enable  <= '0;
            pair_valid <= 1'b0;
            meas_en    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_n;
            k          <= k_n;
            mode_q     <= mode_n;
            cnt        <= cnt_n;
            ro1_sel    <= ro1_n;
            ro2_sel    <= ro2_n;
            ro_enable  <= en_n;
            pair_valid <= pv_n;
            meas_en    <= meas_n;
            done       <= done_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_ro_pair_scheduler.sv
// Scoreboard bench for ro_pair_scheduler: stimulus queues expected pairs and done
// times, a negedge monitor pops and compares as the DUT presents them.
module tb_ro_pair_scheduler;

    localparam int SETTLE = 4;
    localparam int WINDOW = 8;
    localparam int LAT    = 1 + SETTLE + WINDOW;

    typedef struct {
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [15:0] en;
    } pair_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mode = 1'b0, seed_load = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0]  seed = '0;
    logic        busy, pair_valid, meas_en, done;
    logic [3:0]  ro1_sel, ro2_sel;
    logic [15:0] ro_enable;

    int    n_checks = 0;
    int    n_fail = 0;
    int    n_done = 0;
    int    cyc = 0;
    int    meas_cnt = 0;
    logic  pv_prev = 1'b0;
    pair_t exp_q[$];
    int    done_q[$];

    ro_pair_scheduler #(.NUM_RO(16), .LFSR_W(8), .SETTLE(SETTLE), .WINDOW(WINDOW)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .seed_load(seed_load), .seed(seed),
        .start(start), .abort(abort), .busy(busy), .pair_valid(pair_valid),
        .ro1_sel(ro1_sel), .ro2_sel(ro2_sel), .ro_enable(ro_enable),
        .meas_en(meas_en), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pair_t mkp(input int a, input int b);
        pair_t p;
        p.r1 = 4'(a);
        p.r2 = 4'(b);
        p.en = (16'd1 << a) | (16'd1 << b);
        return p;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pair_valid"}, 32'(pair_valid), 0);
        chk({tag, "_ro_enable"}, 32'(ro_enable), 0);
        chk({tag, "_meas_en"}, 32'(meas_en), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ro1"}, 32'(ro1_sel), 0);
        chk({tag, "_ro2"}, 32'(ro2_sel), 1);
    endtask

    task automatic load_seed(input logic [7:0] sd);
        seed_load = 1'b1;
        seed      = sd;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic do_start(input logic m, input logic sl, input logic [7:0] sd);
        mode      = m;
        seed_load = sl;
        seed      = sd;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        done_q.push_back(cyc + LAT);
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 100);
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, t);
        end
    endtask

    task automatic wait_high(input string nm, input bit use_meas);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(use_meas ? meas_en : pair_valid) && t < 100);
        if (!(use_meas ? meas_en : pair_valid)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: signal still 0 after %0d cycles, required 1", nm, t);
        end
    endtask

    // Monitor: pair checked on pair_valid rise, window length and latency on done.
    initial begin
        pair_t p;
        int    e;
        forever begin
            @(negedge clk);
            if (pair_valid && !pv_prev) begin
                meas_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", 32'(ro1_sel), 32'hFFFF);
                end else begin
                    p = exp_q.pop_front();
                    chk("pair_ro1", 32'(ro1_sel), 32'(p.r1));
                    chk("pair_ro2", 32'(ro2_sel), 32'(p.r2));
                    chk("pair_ro_enable", 32'(ro_enable), 32'(p.en));
                    chk("pair_meas_low_in_settle", 32'(meas_en), 0);
                end
            end
            if (meas_en) meas_cnt++;
            if (done) begin
                n_done++;
                chk("window_len", 32'(meas_cnt), 32'(WINDOW));
                chk("done_ro_enable", 32'(ro_enable), 0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(cyc), 32'hFFFF);
                end else begin
                    e = done_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e));
                end
            end
            pv_prev = pair_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        #23;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Seed 1 -> LFSR 0x02 -> pair (2,0)
        load_seed(8'h01);
        exp_q.push_back(mkp(2, 0));
        do_start(1'b0, 1'b0, 8'h00);
        chk("busy_after_start", 32'(busy), 1);
        wait_idle("idle_seed01");
        chk("idle_pv_held", 32'(pair_valid), 1);
        chk("idle_ro1_held", 32'(ro1_sel), 2);
        chk("idle_ro2_held", 32'(ro2_sel), 0);
        chk("idle_ro_enable", 32'(ro_enable), 0);

        // Seed 0x99 -> LFSR 0x33 -> collision 3,3 -> (3,2)
        load_seed(8'h99);
        exp_q.push_back(mkp(3, 2));
        do_start(1'b0, 1'b0, 8'h00);
        wait_idle("idle_seed99");

        // Seed 0 treated as 1
        load_seed(8'h00);
        exp_q.push_back(mkp(2, 0));
        do_start(1'b0, 1'b0, 8'h00);
        wait_idle("idle_seed00");

        // Seed load coincident with start: step(seed)
        exp_q.push_back(mkp(2, 0));
        do_start(1'b0, 1'b1, 8'h01);
        wait_idle("idle_coincident");

        // Abort 3 cycles into MEASURE
        load_seed(8'h01);
        exp_q.push_back(mkp(2, 0));
        do_start(1'b0, 1'b0, 8'h00);
        wait_high("wait_meas_abort", 1'b1);
        repeat (3) @(negedge clk);
        n0 = n_done;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        done_q.delete();
        chk("abort_ro_enable", 32'(ro_enable), 0);
        chk("abort_meas_en", 32'(meas_en), 0);
        chk("abort_pair_valid", 32'(pair_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(n_done), 32'(n0));
        // LFSR advanced 0x02 -> 0x04 -> pair (4,0)
        exp_q.push_back(mkp(4, 0));
        do_start(1'b0, 1'b0, 8'h00);
        wait_idle("idle_after_abort");

        // Sequential, 17 back-to-back from reset
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(mkp(i % 16, (i + 1) % 16));
            do_start(1'b1, 1'b0, 8'h00);
            wait_idle("idle_seq");
        end

        // start while busy is ignored
        n0 = n_done;
        exp_q.push_back(mkp(1, 2));
        do_start(1'b1, 1'b0, 8'h00);
        wait_high("wait_meas_busy", 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("idle_busy_start");
        repeat (20) @(negedge clk);
        chk("busy_start_one_done", 32'(n_done), 32'(n0 + 1));
        chk("busy_start_idle", 32'(busy), 0);

        // Asynchronous reset mid-SETTLE
        exp_q.push_back(mkp(2, 3));
        do_start(1'b1, 1'b0, 8'h00);
        wait_high("wait_pv_reset", 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        done_q.delete();
        n0 = n_done;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midreset_no_done", 32'(n_done), 32'(n0));
        exp_q.push_back(mkp(0, 1));
        do_start(1'b1, 1'b0, 8'h00);
        wait_idle("idle_after_reset");

        repeat (3) @(negedge clk);
        chk("pairs_outstanding", 32'(exp_q.size()), 0);
        chk("dones_outstanding", 32'(done_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
